// File: rtl/cfg_write_arbiter_pkg.sv
// Shared definitions for the config-register write arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cfg_write_arbiter_pkg;

    // Config space is 8 words of 16 bits.
    localparam int CFG_WORDS     = 8;
    localparam int CFG_WORD_BITS = 16;

    // SWEEP_PRIO: sweep wins, FIFO head serves idle cycles.
    // HOST_FORCED: one cycle in which the FIFO head is guaranteed a slot.
    typedef enum logic [0:0] {
        SWEEP_PRIO  = 1'b0,
        HOST_FORCED = 1'b1
    } arb_state_e;

    // Byte enables presented to the config register file.
    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with level output; head is read from storage flops.
// Latency: a pushed entry appears at the head no earlier than the next cycle.
// Backpressure: pushes are ignored while full, pops ignored while empty.
//
// Ports: clk_i/reset_i (sync, active-high); push_i/push_dat_i/full_o write side;
//        pop_i/head_dat_o/empty_o read side; level_o = occupied entries.
module sync_fifo #(
    parameter int WIDTH      = 12,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      push_dat_i,
    output logic                  full_o,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      head_dat_o,
    output logic                  empty_o,
    output logic [LOG2_DEPTH:0]   level_o
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] PTR_ONE = 1;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [LOG2_DEPTH:0] wr_ptr_q;
    logic [LOG2_DEPTH:0] rd_ptr_q;
    logic                push_ok;
    logic                pop_ok;

    // Pointers carry one extra bit, so their difference is the level and
    // its MSB alone means "full" (the level never exceeds DEPTH).
    assign level_o    = wr_ptr_q - rd_ptr_q;
    assign full_o     = level_o[LOG2_DEPTH];
    assign empty_o    = (level_o == '0);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_ptr_q[LOG2_DEPTH-1:0]];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (push_ok && !reset_i) begin
            mem_q[wr_ptr_q[LOG2_DEPTH-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/cfg_write_arbiter.sv
// Arbitrates byte-wide host config writes (queued) against word-wide sweep writes.
// Latency: sweep granted combinationally; host write earliest the cycle after push.
// Backpressure: host_ready from registered FIFO level; sweep_ready low when not granted.
//
// Ports: clk/reset (sync, active-high);
//        host_valid/host_ready/host_addr/host_byte_hi/host_data - queued byte writes;
//        sweep_valid/sweep_ready/sweep_addr/sweep_data - word writes, retried by holding valid;
//        cfg_we/cfg_w_addr/cfg_w_data - single write port to config registers;
//        fifo_level - occupied host FIFO entries.
module cfg_write_arbiter
    import cfg_write_arbiter_pkg::*;
#(
    parameter int CFG_ADDR_BITS   = $clog2(CFG_WORDS),
    parameter int LOG2_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT    = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        host_valid,
    output logic                        host_ready,
    input  logic [CFG_ADDR_BITS-1:0]    host_addr,
    input  logic                        host_byte_hi,
    input  logic [7:0]                  host_data,
    input  logic                        sweep_valid,
    output logic                        sweep_ready,
    input  logic [CFG_ADDR_BITS-1:0]    sweep_addr,
    input  logic [CFG_WORD_BITS-1:0]    sweep_data,
    output logic [1:0]                  cfg_we,
    output logic [CFG_ADDR_BITS-1:0]    cfg_w_addr,
    output logic [CFG_WORD_BITS-1:0]    cfg_w_data,
    output logic [LOG2_FIFO_DEPTH:0]    fifo_level
);

    localparam int ENTRY_W = CFG_ADDR_BITS + 1 + 8;
    localparam int CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;

    arb_state_e               state_q, state_d;
    logic [CNT_W-1:0]         starve_cnt_q, starve_cnt_d;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic [ENTRY_W-1:0]       head_dat;
    logic [CFG_ADDR_BITS-1:0] head_addr;
    logic                     head_hi;
    logic [7:0]               head_byte;
    logic                     sweep_gnt;
    logic                     host_gnt;

    assign host_ready = !fifo_full;

    sync_fifo #(
        .WIDTH      (ENTRY_W),
        .LOG2_DEPTH (LOG2_FIFO_DEPTH)
    ) u_host_fifo (
        .clk_i      (clk),
        .reset_i    (reset),
        .push_i     (host_valid),
        .push_dat_i ({host_addr, host_byte_hi, host_data}),
        .full_o     (fifo_full),
        .pop_i      (host_gnt),
        .head_dat_o (head_dat),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    assign {head_addr, head_hi, head_byte} = head_dat;

    // Grants are masked during reset so the reset cycle never writes config.
    // The head only competes when the sweep is not granted, which also covers
    // HOST_FORCED (sweep never granted there).
    assign sweep_gnt   = !reset && sweep_valid && (state_q == SWEEP_PRIO);
    assign host_gnt    = !reset && !fifo_empty && !sweep_gnt;
    assign sweep_ready = sweep_gnt;

    always_comb begin
        cfg_we     = BE_NONE;
        cfg_w_addr = '0;
        cfg_w_data = '0;
        if (sweep_gnt) begin
            cfg_we     = BE_WORD;
            cfg_w_addr = sweep_addr;
            cfg_w_data = sweep_data;
        end else if (host_gnt) begin
            cfg_we     = head_hi ? BE_HI : BE_LO;
            cfg_w_addr = head_addr;
            cfg_w_data = {head_byte, head_byte};
        end
    end

    // Starvation: count sweep grants that block a waiting head. Switching on
    // the next-state count makes the forced cycle follow the LIMIT-th blocked
    // grant directly, so exactly LIMIT sweeps go through before the host.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (host_gnt || fifo_empty) begin
            starve_cnt_d = '0;
        end else if (state_q == SWEEP_PRIO && sweep_gnt) begin
            starve_cnt_d = starve_cnt_q + CNT_ONE;
        end

        state_d = SWEEP_PRIO;
        if (state_q == SWEEP_PRIO && starve_cnt_d == CNT_LIMIT) begin
            state_d = HOST_FORCED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SWEEP_PRIO;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Self-checking bench for cfg_write_arbiter: expected config writes are queued
// as stimulus is driven and compared in order whenever the DUT writes.
// Latency: n/a. Backpressure: n/a.
module tb_cfg_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_valid;
    logic        host_ready;
    logic [2:0]  host_addr;
    logic        host_byte_hi;
    logic [7:0]  host_data;
    logic        sweep_valid;
    logic        sweep_ready;
    logic [2:0]  sweep_addr;
    logic [15:0] sweep_data;
    logic [1:0]  cfg_we;
    logic [2:0]  cfg_w_addr;
    logic [15:0] cfg_w_data;
    logic [2:0]  fifo_level;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb_q [$];
    bit          mon_en  = 1'b0;

    always #5 clk = ~clk;

    cfg_write_arbiter #(
        .CFG_ADDR_BITS   (3),
        .LOG2_FIFO_DEPTH (2),
        .STARVE_LIMIT    (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_addr    (host_addr),
        .host_byte_hi (host_byte_hi),
        .host_data    (host_data),
        .sweep_valid  (sweep_valid),
        .sweep_ready  (sweep_ready),
        .sweep_addr   (sweep_addr),
        .sweep_data   (sweep_data),
        .cfg_we       (cfg_we),
        .cfg_w_addr   (cfg_w_addr),
        .cfg_w_data   (cfg_w_data),
        .fifo_level   (fifo_level)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] wr(input logic [1:0] we, input logic [2:0] a,
                                       input logic [15:0] d);
        return {11'd0, we, a, d};
    endfunction

    function automatic logic [31:0] host_wr(input logic [2:0] a, input logic hi,
                                            input logic [7:0] d);
        return wr(hi ? 2'b10 : 2'b01, a, {d, d});
    endfunction

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Every config write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [31:0] act;
        logic [31:0] exp;
        if (mon_en && cfg_we !== 2'b00) begin
            act = {11'd0, cfg_we, cfg_w_addr, cfg_w_data};
            if (sb_q.size() == 0) begin
                chk("unexpected_wr", act, 32'd0);
            end else begin
                exp = sb_q.pop_front();
                chk("cfg_wr", act, exp);
            end
        end
    end

    initial begin
        logic       slot;
        logic [2:0] e;
        reset = 1'b1; host_valid = 1'b0; host_addr = '0; host_byte_hi = 1'b0;
        host_data = '0; sweep_valid = 1'b0; sweep_addr = '0; sweep_data = '0;

        // Reset: a valid sweep must not be granted or written.
        adv();
        sweep_valid = 1'b1; sweep_addr = 3'd6; sweep_data = 16'hDEAD;
        @(negedge clk);
        chk("rst_sweep_ready", 32'(sweep_ready), 32'd0);
        chk("rst_cfg_we", 32'(cfg_we), 32'd0);
        adv();
        reset = 1'b0; sweep_valid = 1'b0;
        @(negedge clk);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_host_ready", 32'(host_ready), 32'd1);
        chk("rst_idle_we", 32'(cfg_we), 32'd0);
        mon_en = 1'b1;
        adv();

        // Host only: byte write lands the cycle after the push.
        host_valid = 1'b1; host_addr = 3'd5; host_byte_hi = 1'b1; host_data = 8'hA7;
        sb_q.push_back(wr(2'b10, 3'd5, 16'hA7A7));
        @(negedge clk);
        chk("t1_no_bypass", 32'(cfg_we), 32'd0);
        adv();
        host_valid = 1'b0;
        @(negedge clk);
        chk("t1_host_we", 32'(cfg_we), 32'd2);
        chk("t1_level_held", 32'(fifo_level), 32'd1);
        adv();
        @(negedge clk);
        chk("t1_level_empty", 32'(fifo_level), 32'd0);
        adv();

        // Sweep and queued host entry together: sweep first, host next cycle.
        host_valid = 1'b1; host_addr = 3'd2; host_byte_hi = 1'b0; host_data = 8'h11;
        @(negedge clk);
        adv();
        host_valid = 1'b0;
        sweep_valid = 1'b1; sweep_addr = 3'd3; sweep_data = 16'h0123;
        sb_q.push_back(wr(2'b11, 3'd3, 16'h0123));
        sb_q.push_back(host_wr(3'd2, 1'b0, 8'h11));
        @(negedge clk);
        chk("t2_sweep_ready", 32'(sweep_ready), 32'd1);
        adv();
        sweep_valid = 1'b0;
        @(negedge clk);
        chk("t2_host_next", 32'(cfg_we), 32'd1);
        adv();

        // Starvation: three sweeps, one forced host cycle, then sweeps resume.
        host_valid = 1'b1; host_addr = 3'd1; host_byte_hi = 1'b0; host_data = 8'h55;
        @(negedge clk);
        adv();
        host_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            sweep_valid = 1'b1; sweep_addr = 3'(i); sweep_data = 16'(16'hC000 + i);
            if (i == 4) sb_q.push_back(host_wr(3'd1, 1'b0, 8'h55));
            else        sb_q.push_back(wr(2'b11, 3'(i), 16'(16'hC000 + i)));
            @(negedge clk);
            chk("t3_sweep_ready", 32'(sweep_ready), 32'(i != 4));
            adv();
        end

        // Full FIFO under continuous sweep: 5th push refused, order 1..4 kept.
        for (int k = 0; k <= 17; k++) begin
            sweep_valid = 1'b1; sweep_addr = 3'(k); sweep_data = 16'(16'hB000 + k);
            host_valid  = (k <= 4);
            if (k < 4) begin
                e = 3'(k + 1);
                host_addr = e; host_byte_hi = ~e[0]; host_data = 8'hE0 + 8'(e);
            end else begin
                host_addr = 3'd7; host_byte_hi = 1'b1; host_data = 8'hFF;
            end
            slot = (k == 4) || (k == 8) || (k == 12) || (k == 16);
            if (slot) begin
                e = 3'(k / 4);
                sb_q.push_back(host_wr(e, ~e[0], 8'hE0 + 8'(e)));
            end else begin
                sb_q.push_back(wr(2'b11, 3'(k), 16'(16'hB000 + k)));
            end
            @(negedge clk);
            chk("t4_sweep_ready", 32'(sweep_ready), 32'(!slot));
            if (k == 3) chk("t4_ready_before_full", 32'(host_ready), 32'd1);
            if (k == 4) begin
                chk("t4_ready_full", 32'(host_ready), 32'd0);
                chk("t4_level_full", 32'(fifo_level), 32'd4);
            end
            if (k == 5)  chk("t4_refused_push", 32'(fifo_level), 32'd3);
            if (k == 17) chk("t4_level_drained", 32'(fifo_level), 32'd0);
            adv();
        end
        host_valid = 1'b0;

        // Reset with three queued entries: all are discarded, none written.
        for (int k = 0; k < 3; k++) begin
            sweep_valid = 1'b1; sweep_addr = 3'd5; sweep_data = 16'(16'hA000 + k);
            host_valid = 1'b1; host_addr = 3'(k + 4); host_byte_hi = 1'b0;
            host_data = 8'h30 + 8'(k);
            sb_q.push_back(wr(2'b11, 3'd5, 16'(16'hA000 + k)));
            @(negedge clk);
            chk("t5_sweep_ready", 32'(sweep_ready), 32'd1);
            adv();
        end
        host_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("t5_level_queued", 32'(fifo_level), 32'd3);
        chk("t5_rst_we", 32'(cfg_we), 32'd0);
        chk("t5_rst_sweep_ready", 32'(sweep_ready), 32'd0);
        adv();
        reset = 1'b0; sweep_valid = 1'b0;
        @(negedge clk);
        chk("t5_level_cleared", 32'(fifo_level), 32'd0);
        chk("t5_post_rst_we", 32'(cfg_we), 32'd0);
        chk("t5_host_ready", 32'(host_ready), 32'd1);
        adv();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t5_no_stale_wr", 32'(cfg_we), 32'd0);
            adv();
        end

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
